// File: rtl/sw_debounce_mode.sv
// sw_debounce_mode: synchronise, debounce and one-hot validate the four slide switches
// before they reach the LED pattern FSM.
module sw_debounce_mode #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_sw_raw,
    output logic [3:0] o_sw,
    output logic [3:0] o_mode,
    output logic       o_mode_chg,
    output logic       o_err
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [3:0] s1, s2;
    logic [CW-1:0] cnt [4];
    logic [2:0] ones;
    logic [3:0] next_mode;
    logic next_err;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= 4'b0000;
            s2 <= 4'b0000;
        end else begin
            s1 <= i_sw_raw;
            s2 <= s1;
        end
    end
    // any return to the debounced value restarts the full interval
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sw <= 4'b0000;
            for (int b = 0; b < 4; b++) cnt[b] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (s2[b] == o_sw[b]) cnt[b] <= '0;
                else if (cnt[b] == LAST) begin
                    o_sw[b] <= s2[b];
                    cnt[b] <= '0;
                end else cnt[b] <= cnt[b] + 1'b1;
            end
        end
    end
    always_comb begin
        ones = 3'($countones(o_sw));
        next_mode = (ones == 3'd1) ? o_sw : 4'b0000;
        next_err = ones > 3'd1;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mode <= 4'b0000;
            o_err <= 1'b0;
            o_mode_chg <= 1'b0;
        end else begin
            o_mode <= next_mode;
            o_err <= next_err;
            o_mode_chg <= next_mode != o_mode;
        end
    end
endmodule

// File: tb/tb_sw_debounce_mode.sv
// tb_sw_debounce_mode: directed checks of sync, debounce, validation and reset timing
// with a four-cycle debounce interval.
module tb_sw_debounce_mode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] raw = 4'b0000;
    logic [3:0] o_sw, o_mode;
    logic o_mode_chg, o_err;
    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;
    int base;

    sw_debounce_mode #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sw_raw(raw),
        .o_sw(o_sw),
        .o_mode(o_mode),
        .o_mode_chg(o_mode_chg),
        .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (o_mode_chg) chg_cnt <= chg_cnt + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        raw = 4'b0000;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        raw = 4'b0001;
        rst = 1'b1;
        tick(3);
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL rst_sw got=%b exp=0000", o_sw); end
        checks++; if (o_mode !== 4'b0000) begin errors++; $display("FAIL rst_mode got=%b exp=0000", o_mode); end
        checks++; if (o_mode_chg !== 1'b0) begin errors++; $display("FAIL rst_chg got=%b exp=0", o_mode_chg); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", o_err); end
        base = chg_cnt;
        rst = 1'b0;
        tick(5);
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL single_sw_e4 got=%b exp=0000", o_sw); end
        tick(1);
        checks++; if (o_sw !== 4'b0001) begin errors++; $display("FAIL single_sw_e5 got=%b exp=0001", o_sw); end
        checks++; if (o_mode !== 4'b0000) begin errors++; $display("FAIL single_mode_e5 got=%b exp=0000", o_mode); end
        tick(1);
        checks++; if (o_mode !== 4'b0001) begin errors++; $display("FAIL single_mode_e6 got=%b exp=0001", o_mode); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", o_err); end
        checks++; if (o_mode_chg !== 1'b1) begin errors++; $display("FAIL single_chg got=%b exp=1", o_mode_chg); end
        tick(1);
        checks++; if (o_mode_chg !== 1'b0) begin errors++; $display("FAIL single_chg_end got=%b exp=0", o_mode_chg); end
        tick(3);
        checks++; if (chg_cnt - base !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", chg_cnt - base); end
    endtask

    task automatic test_bounce();
        do_reset();
        base = chg_cnt;
        for (int i = 0; i < 10; i++) begin
            raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            tick(2);
            checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL bounce_sw_%0d got=%b exp=0000", i, o_sw); end
        end
        raw = 4'b0100;
        tick(5);
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL bounce_sw_e4 got=%b exp=0000", o_sw); end
        tick(1);
        checks++; if (o_sw !== 4'b0100) begin errors++; $display("FAIL bounce_sw_e5 got=%b exp=0100", o_sw); end
        tick(1);
        checks++; if (o_mode !== 4'b0100) begin errors++; $display("FAIL bounce_mode got=%b exp=0100", o_mode); end
        tick(3);
        checks++; if (chg_cnt - base !== 1) begin errors++; $display("FAIL bounce_pulses got=%0d exp=1", chg_cnt - base); end
    endtask

    task automatic test_glitch();
        do_reset();
        base = chg_cnt;
        raw = 4'b0001;
        tick(3);
        raw = 4'b0000;
        tick(10);
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL glitch3_sw got=%b exp=0000", o_sw); end
        checks++; if (chg_cnt - base !== 0) begin errors++; $display("FAIL glitch3_pulses got=%0d exp=0", chg_cnt - base); end
        raw = 4'b0001;
        tick(4);
        raw = 4'b0000;
        tick(1);
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL glitch4_sw_e4 got=%b exp=0000", o_sw); end
        tick(1);
        checks++; if (o_sw !== 4'b0001) begin errors++; $display("FAIL glitch4_sw_e5 got=%b exp=0001", o_sw); end
        tick(3);
        checks++; if (o_sw !== 4'b0001) begin errors++; $display("FAIL glitch4_sw_e8 got=%b exp=0001", o_sw); end
        tick(1);
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL glitch4_sw_e9 got=%b exp=0000", o_sw); end
        tick(4);
        checks++; if (chg_cnt - base !== 2) begin errors++; $display("FAIL glitch4_pulses got=%0d exp=2", chg_cnt - base); end
    endtask

    task automatic test_multi();
        do_reset();
        raw = 4'b0001;
        tick(8);
        checks++; if (o_mode !== 4'b0001) begin errors++; $display("FAIL multi_pre got=%b exp=0001", o_mode); end
        base = chg_cnt;
        raw = 4'b0011;
        tick(6);
        checks++; if (o_sw !== 4'b0011) begin errors++; $display("FAIL multi_sw got=%b exp=0011", o_sw); end
        tick(1);
        checks++; if (o_mode !== 4'b0000) begin errors++; $display("FAIL multi_mode got=%b exp=0000", o_mode); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL multi_err got=%b exp=1", o_err); end
        tick(2);
        checks++; if (chg_cnt - base !== 1) begin errors++; $display("FAIL multi_pulses got=%0d exp=1", chg_cnt - base); end
        base = chg_cnt;
        raw = 4'b0010;
        tick(6);
        checks++; if (o_sw !== 4'b0010) begin errors++; $display("FAIL multi_back_sw got=%b exp=0010", o_sw); end
        tick(1);
        checks++; if (o_mode !== 4'b0010) begin errors++; $display("FAIL multi_back_mode got=%b exp=0010", o_mode); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL multi_back_err got=%b exp=0", o_err); end
        tick(2);
        checks++; if (chg_cnt - base !== 1) begin errors++; $display("FAIL multi_back_pulses got=%0d exp=1", chg_cnt - base); end
    endtask

    task automatic test_swap();
        do_reset();
        raw = 4'b1000;
        tick(8);
        base = chg_cnt;
        raw = 4'b0100;
        tick(5);
        checks++; if (o_sw !== 4'b1000) begin errors++; $display("FAIL swap_sw_e4 got=%b exp=1000", o_sw); end
        tick(1);
        checks++; if (o_sw !== 4'b0100) begin errors++; $display("FAIL swap_sw_e5 got=%b exp=0100", o_sw); end
        checks++; if (o_mode !== 4'b1000) begin errors++; $display("FAIL swap_mode_e5 got=%b exp=1000", o_mode); end
        tick(1);
        checks++; if (o_mode !== 4'b0100) begin errors++; $display("FAIL swap_mode_e6 got=%b exp=0100", o_mode); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL swap_err got=%b exp=0", o_err); end
        tick(2);
        checks++; if (chg_cnt - base !== 1) begin errors++; $display("FAIL swap_pulses got=%0d exp=1", chg_cnt - base); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw = 4'b0001;
        tick(8);
        raw = 4'b0010;
        tick(4);
        rst = 1'b1;
        #1;
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL mid_sw got=%b exp=0000", o_sw); end
        checks++; if (o_mode !== 4'b0000) begin errors++; $display("FAIL mid_mode got=%b exp=0000", o_mode); end
        checks++; if (o_err !== 1'b0 || o_mode_chg !== 1'b0) begin errors++; $display("FAIL mid_flags got=%b%b exp=00", o_err, o_mode_chg); end
        tick(1);
        rst = 1'b0;
        tick(5);
        checks++; if (o_sw !== 4'b0000) begin errors++; $display("FAIL mid_sw_f4 got=%b exp=0000", o_sw); end
        tick(1);
        checks++; if (o_sw !== 4'b0010) begin errors++; $display("FAIL mid_sw_f5 got=%b exp=0010", o_sw); end
        tick(1);
        checks++; if (o_mode !== 4'b0010) begin errors++; $display("FAIL mid_mode_f6 got=%b exp=0010", o_mode); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_multi();
        test_swap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
